// File: rtl/tdm_pkg.sv
// Definitions shared by the TDM serializer and deserializer.
// TDM_DEMUX_PARITY_EN adds a trailing even-parity slot to every frame.
package tdm_pkg;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int TDM_PAR_SLOT = 1;
`else
  localparam int TDM_PAR_SLOT = 0;
`endif

  function automatic int slot_w(input int n, input int par);
    return $clog2(n + par);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Frame slot counter: advances on each accepted bit, restarts at 1 on sync.
module tdm_slot_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  input  logic         sync_i,
  input  logic [W-1:0] wrap_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == wrap_i);
  assign cnt_o  = cnt_q;

  // A sync bit is itself slot 0, so the next expected slot is 1.
  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) begin
      if (sync_i)      cnt_d = W'(1);
      else if (last_o) cnt_d = '0;
      else             cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: scatters serial slot bits into an N-bit word behind a valid/ready register.
// TDM_DEMUX_PARITY_EN appends an even-parity slot and drops frames that fail it.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int m  = $clog2(N),
  localparam int F  = N + TDM_PAR_SLOT,
  localparam int SW = slot_w(N, TDM_PAR_SLOT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  logic          din_valid,
  input  logic          frame_sync,
  output logic [SW-1:0] slot,
  output logic [N-1:0]  out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overrun,
  output logic          parity_err
);

  localparam logic [SW-1:0] WRAP = SW'(F - 1);

  logic [SW-1:0] cnt;
  logic          last;
  logic          complete;
  logic          data_slot;
  logic          par_bad;

  logic [N-1:0]  shadow_q, shadow_d;
  logic [N-1:0]  out_q, out_d;
  logic          vld_q, vld_d;
  logic          ovr_q, ovr_d;
  logic          perr_q, perr_d;

  tdm_slot_counter #(.W(SW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .adv_i  (din_valid),
    .sync_i (frame_sync),
    .wrap_i (WRAP),
    .cnt_o  (cnt),
    .last_o (last)
  );

  // A sync on the final slot restarts the frame instead of completing it.
  assign complete = din_valid & ~frame_sync & last;

`ifdef TDM_DEMUX_PARITY_EN
  assign data_slot = ~last;
  assign par_bad   = ^{shadow_q, din};
`else
  assign data_slot = 1'b1;
  assign par_bad   = 1'b0;
`endif

  always_comb begin
    shadow_d = shadow_q;
    if (din_valid) begin
      if (frame_sync)     shadow_d = {{(N-1){1'b0}}, din};
      else if (data_slot) shadow_d[cnt[m-1:0]] = din;
    end
  end

  // shadow_d already holds the final data bit when no parity slot follows it.
  always_comb begin
    out_d  = out_q;
    vld_d  = vld_q;
    ovr_d  = 1'b0;
    perr_d = 1'b0;
    if (vld_q && out_ready) vld_d = 1'b0;
    if (complete) begin
      if (par_bad) begin
        perr_d = 1'b1;
      end else if (!vld_q || out_ready) begin
        out_d = shadow_d;
        vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
      ovr_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      ovr_q    <= ovr_d;
      perr_q   <= perr_d;
    end
  end

  assign slot       = cnt;
  assign out        = out_q;
  assign out_valid  = vld_q;
  assign overrun    = ovr_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed frame table, corner sequences, random vs. model.
module tb_tdm_demux;
  import tdm_pkg::*;

  localparam int N  = 8;
  localparam int F  = N + TDM_PAR_SLOT;
  localparam int SW = slot_w(N, TDM_PAR_SLOT);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          frame_sync = 1'b0;
  logic          out_ready = 1'b0;
  logic [SW-1:0] slot;
  logic [N-1:0]  dout;
  logic          out_valid;
  logic          overrun;
  logic          parity_err;

  int total = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_out;
  } vec_t;
  vec_t vecs[8];

  // reference model: bits of the frame in progress, plus the output register
  bit         mq[$];
  logic [7:0] m_out;
  bit         m_vld, m_ovr, m_perr;

  always #5 clk = ~clk;

  tdm_demux #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .slot       (slot),
    .out        (dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    din = b; frame_sync = s; din_valid = 1'b1;
    tick();
    din = 1'b0; frame_sync = 1'b0; din_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic bad_par, input bit gaps);
    for (int i = 0; i < F; i++) begin
      logic b;
      b = (i < N) ? w[i] : ((^w) ^ bad_par);
      send_bit(b, i == 0);
      if (gaps) tick();
    end
  endtask

  task automatic chk_all(input string tag, input int e_out, input int e_vld,
                         input int e_ovr, input int e_perr);
    chk({tag, ".out"},  dout, e_out);
    chk({tag, ".vld"},  out_valid, e_vld);
    chk({tag, ".ovr"},  overrun, e_ovr);
    chk({tag, ".perr"}, parity_err, e_perr);
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; frame_sync = 1'b0; din = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic model_step();
    bit consumed;
    m_ovr = 0; m_perr = 0;
    consumed = m_vld && out_ready;
    if (din_valid) begin
      if (frame_sync) begin
        mq.delete();
        mq.push_back(din);
      end else begin
        mq.push_back(din);
        if (mq.size() == F) begin
          logic [7:0] w;
          int ones;
          ones = 0;
          for (int i = 0; i < F; i++) ones += int'(mq[i]);
          for (int i = 0; i < N; i++) w[i] = mq[i];
          mq.delete();
          if (TDM_PAR_SLOT == 1 && (ones % 2) == 1) m_perr = 1;
          else if (!m_vld || out_ready) begin
            m_out = w; m_vld = 1; consumed = 0;
          end else m_ovr = 1;
        end
      end
    end
    if (consumed) m_vld = 0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'hA5};
    vecs[1] = '{8'h3C, 8'h3C};
    vecs[2] = '{8'hFF, 8'hFF};
    vecs[3] = '{8'h00, 8'h00};
    vecs[4] = '{8'h81, 8'h81};
    vecs[5] = '{8'h5A, 8'h5A};
    vecs[6] = '{8'h01, 8'h01};
    vecs[7] = '{8'h80, 8'h80};

    tick();
    do_reset();
    chk("rst.slot", slot, 0);
    chk_all("rst", 0, 0, 0, 0);

    // frame table with the consumer always ready
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].word, 1'b0, 1'b0);
      chk("tbl.slot", slot, 0);
      chk_all("tbl", vecs[v].exp_out, 1, 0, 0);
      tick();
      chk("tbl.drain", out_valid, 0);
    end

    // stall: second frame overruns, first word held
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    chk_all("stall1", 8'h3C, 1, 0, 0);
    send_frame(8'hFF, 1'b0, 1'b0);
    chk_all("stall2", 8'h3C, 1, 1, 0);
    tick();
    chk_all("stall3", 8'h3C, 1, 0, 0);
    out_ready = 1'b1;
    tick();
    chk("stall.drain", out_valid, 0);

    // load and accept in the same cycle
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0);
    chk_all("same1", 8'h11, 1, 0, 0);
    for (int i = 0; i < F; i++) begin
      logic [7:0] w2;
      logic b;
      w2 = 8'h22;
      b = (i < N) ? w2[i] : (^w2);
      if (i == F - 1) out_ready = 1'b1;
      send_bit(b, i == 0);
    end
    chk_all("same2", 8'h22, 1, 0, 0);
    tick();
    chk("same.drain", out_valid, 0);

    // resync after a partial frame, with gaps in din_valid
    out_ready = 1'b0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("resync.slot3", slot, 3);
    chk("resync.novld", out_valid, 0);
    send_frame(8'h81, 1'b0, 1'b1);
    chk("resync.slot", slot, 0);
    chk_all("resync", 8'h81, 1, 0, 0);
    out_ready = 1'b1;
    tick();
    chk("resync.drain", out_valid, 0);

    // reset mid-frame with a word pending
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    chk("mid.slot5", slot, 5);
    do_reset();
    chk("mid.slot", slot, 0);
    chk_all("midrst", 0, 0, 0, 0);
    out_ready = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0);
    chk_all("after", 8'h5A, 1, 0, 0);
    tick();

`ifdef TDM_DEMUX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b0);
    chk_all("par.ok", 8'h07, 1, 0, 0);
    tick();
    send_frame(8'h07, 1'b1, 1'b0);
    chk_all("par.bad", 8'h07, 0, 0, 1);
    tick();
    chk("par.pulse", parity_err, 0);
`endif

    // randomized traffic against the model
    do_reset();
    mq.delete();
    m_out = '0; m_vld = 0; m_ovr = 0; m_perr = 0;
    for (int c = 0; c < 3000; c++) begin
      din        = 1'($urandom_range(0, 1));
      din_valid  = ($urandom_range(0, 3) != 0);
      frame_sync = ($urandom_range(0, 11) == 0);
      out_ready  = 1'($urandom_range(0, 1));
      model_step();
      tick();
      chk("rnd.slot", slot, mq.size());
      chk_all("rnd", m_out, m_vld, m_ovr, m_perr);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
